// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the slice-serial adder.
// NSLICE and CNT_W are derived here so every file agrees on the slice count.
package nibble_serial_adder_pkg;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_slice_add.sv
// Combinational SLICE-bit adder; the top reuses one instance every RUN cycle.
module slice_add
    import nibble_serial_adder_pkg::*;
#(
    parameter int W = SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] total;

    // Zero-extend every term so the slice carry lands in bit W.
    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s     = total[W-1:0];
    assign co    = total[W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Slice-serial WIDTH-bit adder: latches operands in IDLE, adds one SLICE per
// RUN cycle through a registered carry, then holds the result in DONE.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             invB,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A_q,
    output logic [WIDTH-1:0] B_q,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             co_sl;
    logic             last_slice;

    assign a_sl       = A_q[cnt_q*SLICE +: SLICE];
    assign b_sl       = B_q[cnt_q*SLICE +: SLICE];
    assign last_slice = (cnt_q == LAST_SLICE);

    slice_add #(.W(SLICE)) u_slice_add (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry_q),
        .s  (s_sl),
        .co (co_sl)
    );

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath is frozen on flush; results stay visible but out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A_q       <= '0;
            B_q       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
        end else if (!flush) begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        A_q     <= A;
                        B_q     <= invB ? ~B : B;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum[cnt_q*SLICE +: SLICE] <= s_sl;
                    carry_q                   <= co_sl;
                    cnt_q                     <= cnt_q + 1'b1;
                    if (last_slice) carry_out <= co_sl;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against a plain
// arithmetic reference: {carry, sum} = A + effective B + cin.
module tb_nibble_serial_adder;

    localparam int W       = 16;
    localparam int NSL     = 4;
    localparam int MAX_LAT = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          inv_b;
    logic          cin;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum;
    logic          carry_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .invB      (inv_b),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_q       (a_q),
        .B_q       (b_q),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
    task automatic do_add(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic inv_i, input logic cin_i, input int hold);
        logic [W-1:0] beff;
        logic [W:0]   full;
        int           edges;
        beff = inv_i ? ~b_i : b_i;
        full = {1'b0, a_i} + {1'b0, beff} + {{W{1'b0}}, cin_i};

        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = a_i; b = b_i; inv_b = inv_i; cin = cin_i;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); inv_b = 1'($urandom); cin = 1'($urandom);
        check("run_in_ready", 32'(in_ready), 32'd0);

        edges = 0;
        while (!out_valid && edges < MAX_LAT) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(NSL));
        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(full[W]));
        check("a_q", 32'(a_q), 32'(a_i));
        check("b_q", 32'(b_q), 32'(beff));

        // Stall in DONE while a new request knocks; it must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(full[W-1:0]));
            check("hold_b_q", 32'(b_q), 32'(beff));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_a_q", 32'(a_q), 32'(a_i));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; inv_b = 1'b0; cin = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_a_q", 32'(a_q), 32'd0);
        check("rst_b_q", 32'(b_q), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_add(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_add(16'hABCD, 16'h1357, 1'b0, 1'b1, 3);

        // Flush on the second RUN edge: back to IDLE, no result appears.
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; inv_b = 1'b0; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        do_add(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        // Asynchronous reset mid-RUN clears everything immediately.
        in_valid = 1'b1; a = 16'h8888; b = 16'h7777; inv_b = 1'b0; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_a_q", 32'(a_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_add(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 1);

        for (int n = 0; n < 40; n++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
